// File: rtl/seq_checker.sv
// seq_checker: receive-side monitor for the 3-bit irregular-sequence counter.
// It predicts each sample from the previous one, locks after LOCK_N
// consecutive correct transitions, and pulses Err on mispredictions while
// locked. It drops lock after UNLOCK_N consecutive misses.
// Optional build macro SEQ_CHK_TRANSIENT_EN: a transient value (001/010/101)
// seen while locked forces an immediate return to TRACK.
module seq_checker #(
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Valid,
  input  logic [2:0]       Din,
  input  logic             Resync,
  input  logic             ClrCnt,
  output logic             Locked,
  output logic             Err,
  output logic [2:0]       Expected,
  output logic [CNT_W-1:0] ErrCnt,
  output logic [1:0]       FsmState
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [3:0] LOCK_TH   = 4'(LOCK_N);
  localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_N);

  // Successor of a counter state in the irregular sequence.
  function automatic logic [2:0] next_of(input logic [2:0] p);
    logic [2:0] n;
    case (p)
      3'b000:  n = 3'b110;
      3'b001:  n = 3'b110;
      3'b010:  n = 3'b111;
      3'b011:  n = 3'b000;
      3'b100:  n = 3'b111;
      3'b101:  n = 3'b010;
      3'b110:  n = 3'b100;
      3'b111:  n = 3'b011;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

`ifdef SEQ_CHK_TRANSIENT_EN
  // Values off the main cycle; the counter only passes through them.
  function automatic logic is_transient(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b101);
  endfunction
`endif

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       p_r;
  logic [2:0]       p_s;
  logic [3:0]       match_cnt_r;
  logic [3:0]       match_cnt_s;
  logic [3:0]       miss_cnt_r;
  logic [3:0]       miss_cnt_s;
  logic             err_inc_s;
  logic             hit_s;
  logic             miss_s;
  logic             force_track_s;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] err_cnt_s;
  logic             locked_r;
  logic             locked_s;
  logic             err_r;
  logic [2:0]       expected_r;
  logic [2:0]       expected_s;

  assign hit_s = (Din == next_of(p_r));
`ifdef SEQ_CHK_TRANSIENT_EN
  assign force_track_s = is_transient(Din);
  assign miss_s        = !hit_s || force_track_s;
`else
  assign force_track_s = 1'b0;
  assign miss_s        = !hit_s;
`endif

  // Registers for FSM, history, counters and all outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= HUNT;
      p_r         <= 3'b000;
      match_cnt_r <= 4'd0;
      miss_cnt_r  <= 4'd0;
      err_cnt_r   <= {CNT_W{1'b0}};
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      expected_r  <= 3'b000;
    end else begin
      state_r     <= state_s;
      p_r         <= p_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      err_cnt_r   <= err_cnt_s;
      locked_r    <= locked_s;
      err_r       <= err_inc_s;
      expected_r  <= expected_s;
    end
  end

  // Next-state logic: Resync beats a sample; no sample means hold.
  always_comb begin
    state_s     = state_r;
    p_s         = p_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    err_inc_s   = 1'b0;
    if (Resync) begin
      state_s     = HUNT;
      match_cnt_s = 4'd0;
      miss_cnt_s  = 4'd0;
    end else if (Valid) begin
      p_s = Din;
      case (state_r)
        HUNT: begin
          state_s     = TRACK;
          match_cnt_s = 4'd0;
        end
        TRACK: begin
          if (hit_s) begin
            if (match_cnt_r + 4'd1 == LOCK_TH) begin
              state_s     = LOCKED;
              match_cnt_s = 4'd0;
              miss_cnt_s  = 4'd0;
            end else begin
              match_cnt_s = match_cnt_r + 4'd1;
            end
          end else begin
            match_cnt_s = 4'd0;
          end
        end
        LOCKED: begin
          if (!miss_s) begin
            miss_cnt_s = 4'd0;
          end else begin
            err_inc_s = 1'b1;
            if (force_track_s || (miss_cnt_r + 4'd1 == UNLOCK_TH)) begin
              state_s     = TRACK;
              match_cnt_s = 4'd0;
              miss_cnt_s  = 4'd0;
            end else begin
              miss_cnt_s = miss_cnt_r + 4'd1;
            end
          end
        end
        default: begin
          state_s     = HUNT;
          match_cnt_s = 4'd0;
          miss_cnt_s  = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output next values: error tally with clear priority, lock flag, prediction.
  always_comb begin
    err_cnt_s = err_cnt_r;
    if (ClrCnt) begin
      err_cnt_s = err_inc_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
    end else if (err_inc_s && (err_cnt_r != {CNT_W{1'b1}})) begin
      err_cnt_s = err_cnt_r + CNT_W'(1'b1);
    end else begin
      err_cnt_s = err_cnt_r;
    end
    locked_s = (state_s == LOCKED);
    if (state_s == HUNT) begin
      expected_s = 3'b000;
    end else begin
      expected_s = next_of(p_s);
    end
  end

  assign Locked   = locked_r;
  assign Err      = err_r;
  assign Expected = expected_r;
  assign ErrCnt   = err_cnt_r;
  assign FsmState = state_r;

endmodule
